// File: rtl/lbr_pkg.sv
// Shared encodings for the Last Branch Record unit: branch types, window regions,
// control register indices and CTRL bit positions.
package lbr_pkg;

    typedef enum logic [2:0] {
        BR_COND = 3'd0,
        BR_JAL  = 3'd1,
        BR_JALR = 3'd2,
        BR_CALL = 3'd3,
        BR_RET  = 3'd4
    } br_type_e;

    typedef enum logic [1:0] {
        RGN_FROM = 2'b00,
        RGN_TO   = 2'b01,
        RGN_INFO = 2'b10,
        RGN_CTRL = 2'b11
    } region_e;

    localparam int CTRL_IDX_TOS   = 0;
    localparam int CTRL_IDX_CTRL  = 1;
    localparam int CTRL_IDX_COUNT = 2;

    localparam int CTRL_BIT_EN        = 0;
    localparam int CTRL_BIT_FREEZE_EN = 1;
    localparam int CTRL_BIT_FROZEN    = 2;
    localparam int CTRL_MASK_LSB      = 8;

    localparam logic [7:0] TYPE_MASK_RST = 8'hFF;

    localparam int INFO_W         = 4;
    localparam int INFO_VALID_BIT = 3;

endpackage

// File: rtl/lbr_entry_ram.sv
// LBR entry storage: from/to/info arrays, each with one synchronous write port,
// asynchronous clear and a combinational read port.
module lbr_entry_ram
    import lbr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LBR_SIZE   = 16,
    localparam int IDX_W     = $clog2(LBR_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  from_we,
    input  logic                  to_we,
    input  logic                  info_we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wfrom,
    input  logic [DATA_WIDTH-1:0] wto,
    input  logic [INFO_W-1:0]     winfo,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rfrom,
    output logic [DATA_WIDTH-1:0] rto,
    output logic [INFO_W-1:0]     rinfo
);

    logic [DATA_WIDTH-1:0] from_q [LBR_SIZE];
    logic [DATA_WIDTH-1:0] to_q   [LBR_SIZE];
    logic [INFO_W-1:0]     info_q [LBR_SIZE];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LBR_SIZE; i++) from_q[i] <= '0;
        end else if (from_we) begin
            from_q[waddr] <= wfrom;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LBR_SIZE; i++) to_q[i] <= '0;
        end else if (to_we) begin
            to_q[waddr] <= wto;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LBR_SIZE; i++) info_q[i] <= '0;
        end else if (info_we) begin
            info_q[waddr] <= winfo;
        end
    end

    assign rfrom = from_q[raddr];
    assign rto   = to_q[raddr];
    assign rinfo = info_q[raddr];

endmodule

// File: rtl/lbr_filter_unit.sv
// Last Branch Record unit: filtered logging of taken control transfers into a
// circular buffer, with freeze-on-full and an addressed CSR window.
module lbr_filter_unit
    import lbr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LBR_SIZE   = 16,
    localparam int ADDR_W    = $clog2(LBR_SIZE) + 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  br_valid,
    input  logic [2:0]            br_type,
    input  logic [DATA_WIDTH-1:0] br_from,
    input  logic [DATA_WIDTH-1:0] br_to,
    input  logic [1:0]            csr_req,
    input  logic [ADDR_W-1:0]     csr_addr,
    input  logic [DATA_WIDTH-1:0] csr_wdata,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_rvalid,
    output logic                  freeze_irq
);

    localparam int IDX_W = $clog2(LBR_SIZE);
    localparam int CNT_W = $clog2(LBR_SIZE + 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(LBR_SIZE);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(LBR_SIZE - 1);

    function automatic logic [CNT_W-1:0] sat_count(input logic [DATA_WIDTH-1:0] v);
        if (v > DATA_WIDTH'(LBR_SIZE)) return COUNT_MAX;
        return v[CNT_W-1:0];
    endfunction

    logic [IDX_W-1:0]      tos_q, tos_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  enable_q, enable_d;
    logic                  freeze_en_q, freeze_en_d;
    logic                  frozen_q, frozen_d;
    logic [7:0]            type_mask_q, type_mask_d;
    logic [DATA_WIDTH-1:0] csr_rdata_q, csr_rdata_d;
    logic                  csr_rvalid_q, csr_rvalid_d;
    logic                  freeze_irq_q, freeze_irq_d;

    logic                  csr_wr, csr_rd, record;
    logic [1:0]            region;
    logic [IDX_W-1:0]      idx;
    logic                  from_we, to_we, info_we;
    logic [IDX_W-1:0]      ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wfrom, ram_wto;
    logic [INFO_W-1:0]     ram_winfo;
    logic [DATA_WIDTH-1:0] rfrom, rto;
    logic [INFO_W-1:0]     rinfo;
    logic [DATA_WIDTH-1:0] rd_val, ctrl_word;

    assign csr_wr = (csr_req == 2'b11);
    assign csr_rd = (csr_req == 2'b10);
    assign region = csr_addr[ADDR_W-1 -: 2];
    assign idx    = csr_addr[IDX_W-1:0];

    // Any CSR write in the same cycle wins over a branch, which is then lost.
    assign record = br_valid & ~stall & enable_q & ~frozen_q & type_mask_q[br_type] & ~csr_wr;

    always_comb begin
        ram_waddr = record ? tos_q : idx;
        ram_wfrom = record ? br_from : csr_wdata;
        ram_wto   = record ? br_to : csr_wdata;
        ram_winfo = record ? {1'b1, br_type} : csr_wdata[INFO_W-1:0];
        from_we   = record | (csr_wr & (region == RGN_FROM));
        to_we     = record | (csr_wr & (region == RGN_TO));
        info_we   = record | (csr_wr & (region == RGN_INFO));
    end

    lbr_entry_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .LBR_SIZE   (LBR_SIZE)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .from_we (from_we),
        .to_we   (to_we),
        .info_we (info_we),
        .waddr   (ram_waddr),
        .wfrom   (ram_wfrom),
        .wto     (ram_wto),
        .winfo   (ram_winfo),
        .raddr   (idx),
        .rfrom   (rfrom),
        .rto     (rto),
        .rinfo   (rinfo)
    );

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_BIT_EN]        = enable_q;
        ctrl_word[CTRL_BIT_FREEZE_EN] = freeze_en_q;
        ctrl_word[CTRL_BIT_FROZEN]    = frozen_q;
        ctrl_word[CTRL_MASK_LSB +: 8] = type_mask_q;
    end

    // Reads observe current (pre-update) state, so a concurrent record is not visible.
    always_comb begin
        rd_val = '0;
        case (region)
            RGN_FROM: rd_val = rfrom;
            RGN_TO:   rd_val = rto;
            RGN_INFO: rd_val = DATA_WIDTH'(rinfo);
            default: begin
                case (int'(idx))
                    CTRL_IDX_TOS:   rd_val = DATA_WIDTH'(tos_q);
                    CTRL_IDX_CTRL:  rd_val = ctrl_word;
                    CTRL_IDX_COUNT: rd_val = DATA_WIDTH'(count_q);
                    default:        rd_val = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        enable_d    = enable_q;
        freeze_en_d = freeze_en_q;
        frozen_d    = frozen_q;
        type_mask_d = type_mask_q;

        if (record) begin
            tos_d   = tos_q + 1'b1;
            count_d = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + 1'b1;
            if (freeze_en_q && tos_q == LAST_SLOT) frozen_d = 1'b1;
        end

        if (csr_wr && region == RGN_CTRL) begin
            case (int'(idx))
                CTRL_IDX_TOS:   tos_d = csr_wdata[IDX_W-1:0];
                CTRL_IDX_CTRL: begin
                    enable_d    = csr_wdata[CTRL_BIT_EN];
                    freeze_en_d = csr_wdata[CTRL_BIT_FREEZE_EN];
                    frozen_d    = csr_wdata[CTRL_BIT_FROZEN];
                    type_mask_d = csr_wdata[CTRL_MASK_LSB +: 8];
                end
                CTRL_IDX_COUNT: count_d = sat_count(csr_wdata);
                default: ;
            endcase
        end

        csr_rvalid_d = csr_rd;
        csr_rdata_d  = csr_rd ? rd_val : csr_rdata_q;
        freeze_irq_d = frozen_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tos_q        <= '0;
            count_q      <= '0;
            enable_q     <= 1'b0;
            freeze_en_q  <= 1'b0;
            frozen_q     <= 1'b0;
            type_mask_q  <= TYPE_MASK_RST;
            csr_rdata_q  <= '0;
            csr_rvalid_q <= 1'b0;
            freeze_irq_q <= 1'b0;
        end else begin
            tos_q        <= tos_d;
            count_q      <= count_d;
            enable_q     <= enable_d;
            freeze_en_q  <= freeze_en_d;
            frozen_q     <= frozen_d;
            type_mask_q  <= type_mask_d;
            csr_rdata_q  <= csr_rdata_d;
            csr_rvalid_q <= csr_rvalid_d;
            freeze_irq_q <= freeze_irq_d;
        end
    end

    assign csr_rdata  = csr_rdata_q;
    assign csr_rvalid = csr_rvalid_q;
    assign freeze_irq = freeze_irq_q;

endmodule

// File: tb/tb_lbr_filter_unit.sv
// Directed bench for lbr_filter_unit with LBR_SIZE=4: table-driven register reads
// per phase plus hand-written multi-cycle sequences (stall, freeze, collision, reset).
module tb_lbr_filter_unit;

    localparam int DW     = 64;
    localparam int SIZE   = 4;
    localparam int AW     = 4;
    localparam logic [3:0] A_TOS   = 4'd12;
    localparam logic [3:0] A_CTRL  = 4'd13;
    localparam logic [3:0] A_COUNT = 4'd14;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          br_valid = 1'b0;
    logic [2:0]    br_type = '0;
    logic [DW-1:0] br_from = '0;
    logic [DW-1:0] br_to = '0;
    logic [1:0]    csr_req = '0;
    logic [AW-1:0] csr_addr = '0;
    logic [DW-1:0] csr_wdata = '0;
    logic [DW-1:0] csr_rdata;
    logic          csr_rvalid;
    logic          freeze_irq;

    int checks = 0;
    int errors = 0;

    lbr_filter_unit #(.DATA_WIDTH(DW), .LBR_SIZE(SIZE)) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_type    (br_type),
        .br_from    (br_from),
        .br_to      (br_to),
        .csr_req    (csr_req),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_rvalid (csr_rvalid),
        .freeze_irq (freeze_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            phase;
        logic [3:0]    addr;
        logic [DW-1:0] exp;
        string         name;
    } rd_vec_t;

    rd_vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic csr_write(input logic [3:0] addr, input logic [DW-1:0] data);
        csr_req = 2'b11; csr_addr = addr; csr_wdata = data;
        step();
        csr_req = 2'b00;
    endtask

    task automatic csr_read(input logic [3:0] addr, output logic [DW-1:0] data);
        csr_req = 2'b10; csr_addr = addr;
        step();
        data = csr_rdata;
        check("rvalid_pulse", {63'd0, csr_rvalid}, 64'd1);
        csr_req = 2'b00;
    endtask

    task automatic branch(input logic [2:0] t, input logic [DW-1:0] f, input logic [DW-1:0] to);
        br_valid = 1'b1; br_type = t; br_from = f; br_to = to;
        step();
        br_valid = 1'b0;
    endtask

    task automatic run_phase(input int p);
        logic [DW-1:0] d;
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                csr_read(vecs[i].addr, d);
                check(vecs[i].name, d, vecs[i].exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;

        vecs = '{
            '{1, 4'd0,  64'h100, "p1_from0"},
            '{1, 4'd4,  64'h200, "p1_to0"},
            '{1, 4'd8,  64'h9,   "p1_info0"},
            '{1, A_TOS, 64'd1,   "p1_tos"},
            '{1, A_COUNT, 64'd1, "p1_count"},
            '{2, A_TOS, 64'd1,   "p2_tos_stall"},
            '{2, A_COUNT, 64'd1, "p2_count_stall"},
            '{2, 4'd1,  64'h0,   "p2_from1_stall"},
            '{2, 4'd9,  64'h0,   "p2_info1_stall"},
            '{3, 4'd1,  64'h700, "p3_from1"},
            '{3, 4'd5,  64'h800, "p3_to1"},
            '{3, 4'd9,  64'hA,   "p3_info1"},
            '{3, A_TOS, 64'd2,   "p3_tos"},
            '{3, A_COUNT, 64'd2, "p3_count"},
            '{4, A_CTRL, 64'hFF07, "p4_ctrl_frozen"},
            '{4, A_TOS, 64'd0,   "p4_tos"},
            '{4, A_COUNT, 64'd4, "p4_count"},
            '{4, 4'd0,  64'h1000, "p4_from0"},
            '{4, 4'd3,  64'h1030, "p4_from3"},
            '{4, 4'd6,  64'h2020, "p4_to2"},
            '{4, 4'd11, 64'h8,   "p4_info3"},
            '{5, A_TOS, 64'd2,   "p5_tos"},
            '{5, A_COUNT, 64'd4, "p5_count"},
            '{5, 4'd0,  64'h4004, "p5_from0"},
            '{5, 4'd1,  64'h4005, "p5_from1"},
            '{5, 4'd2,  64'h4002, "p5_from2"},
            '{5, 4'd3,  64'h4003, "p5_from3"},
            '{5, 4'd8,  64'hC,   "p5_info0"},
            '{6, A_TOS, 64'd3,   "p6_tos"},
            '{6, A_COUNT, 64'd4, "p6_count"},
            '{6, 4'd2,  64'h4002, "p6_from2"},
            '{7, 4'd0,  64'h0,   "p7_from0"},
            '{7, 4'd4,  64'h0,   "p7_to0"},
            '{7, 4'd8,  64'h0,   "p7_info0"},
            '{7, 4'd3,  64'h0,   "p7_from3"},
            '{7, A_TOS, 64'd0,   "p7_tos"},
            '{7, A_COUNT, 64'd0, "p7_count"},
            '{7, A_CTRL, 64'hFF00, "p7_ctrl"}
        };

        // Reset state
        #12;
        check("rst_rdata", csr_rdata, 64'd0);
        check("rst_rvalid", {63'd0, csr_rvalid}, 64'd0);
        check("rst_irq", {63'd0, freeze_irq}, 64'd0);
        step();
        reset = 1'b1;
        step();
        csr_read(A_CTRL, d);
        check("rst_ctrl", d, 64'hFF00);
        step();
        check("rvalid_drops", {63'd0, csr_rvalid}, 64'd0);
        check("rdata_holds", csr_rdata, 64'hFF00);
        csr_read(A_TOS, d);
        check("rst_tos", d, 64'd0);
        csr_read(A_COUNT, d);
        check("rst_count", d, 64'd0);

        // Basic record
        csr_write(A_CTRL, 64'hFF01);
        branch(3'd1, 64'h100, 64'h200);
        run_phase(1);

        // Stall suppresses recording
        stall = 1'b1;
        branch(3'd1, 64'h300, 64'h400);
        stall = 1'b0;
        run_phase(2);

        // Type mask filters JAL
        csr_write(A_CTRL, 64'hFD01);
        branch(3'd1, 64'h500, 64'h600);
        branch(3'd2, 64'h700, 64'h800);
        run_phase(3);

        // Freeze on full
        csr_write(A_CTRL, 64'hFF03);
        csr_write(A_TOS, 64'd0);
        for (int i = 0; i < 4; i++) begin
            branch(3'd0, 64'h1000 + 64'(i * 16), 64'h2000 + 64'(i * 16));
            check("irq_during_fill", {63'd0, freeze_irq}, (i == 3) ? 64'd1 : 64'd0);
        end
        branch(3'd0, 64'h1040, 64'h2040);
        run_phase(4);
        csr_write(A_CTRL, 64'hFF03);
        check("irq_cleared", {63'd0, freeze_irq}, 64'd0);
        branch(3'd3, 64'h3000, 64'h3100);
        csr_read(4'd0, d);
        check("resume_from0", d, 64'h3000);
        csr_read(A_TOS, d);
        check("resume_tos", d, 64'd1);

        // COUNT write saturation, then wrap without freeze
        csr_write(A_COUNT, 64'd9);
        csr_read(A_COUNT, d);
        check("count_wr_sat", d, 64'd4);
        csr_write(A_CTRL, 64'hFF01);
        csr_write(A_TOS, 64'd0);
        csr_write(A_COUNT, 64'd1);
        for (int i = 0; i < 6; i++) branch(3'd4, 64'h4000 + 64'(i), 64'h5000 + 64'(i));
        run_phase(5);

        // Collision: CSR write beats branch
        csr_req = 2'b11; csr_addr = A_TOS; csr_wdata = 64'd3;
        br_valid = 1'b1; br_type = 3'd0; br_from = 64'h9999; br_to = 64'h8888;
        step();
        csr_req = 2'b00; br_valid = 1'b0;
        run_phase(6);

        // Read in the same cycle as a record sees pre-record state
        csr_req = 2'b10; csr_addr = A_TOS;
        br_valid = 1'b1; br_type = 3'd0; br_from = 64'hAAAA; br_to = 64'hBBBB;
        step();
        csr_req = 2'b00; br_valid = 1'b0;
        check("rbw_tos", csr_rdata, 64'd3);
        csr_read(4'd3, d);
        check("rbw_from3", d, 64'hAAAA);
        csr_read(A_TOS, d);
        check("rbw_tos_wrap", d, 64'd0);

        // Freeze again, then asynchronous reset mid-cycle
        csr_write(A_CTRL, 64'hFF03);
        csr_write(A_TOS, 64'd3);
        branch(3'd0, 64'hC000, 64'hD000);
        check("irq_refreeze", {63'd0, freeze_irq}, 64'd1);
        csr_read(4'd3, d);
        check("pre_rst_from3", d, 64'hC000);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_irq", {63'd0, freeze_irq}, 64'd0);
        check("async_rst_rdata", csr_rdata, 64'd0);
        check("async_rst_rvalid", {63'd0, csr_rvalid}, 64'd0);
        step();
        step();
        reset = 1'b1;
        step();
        run_phase(7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbr_filter_unit.md
Name: lbr_filter_unit

Overview:
Second-generation Last Branch Record unit for the BRISC-V core. It logs taken control transfers into a circular buffer of LBR_SIZE {from, to, info} entries. Each branch type can be filtered individually, and the buffer can freeze when full with an interrupt to software. It sits beside the execute stage, is fed resolved branch info, and is accessed by the CSR/load-store path through an addressed register window.

Parameters:
DATA_WIDTH, 64, width of PCs and CSR data
LBR_SIZE, 16, entry count; power of two, >= 2
ADDR_W, $clog2(LBR_SIZE)+2, CSR window address width (derived; do not override)

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-low reset
stall  input  1  pipeline stall; suppresses branch recording
br_valid  input  1  taken control transfer resolved this cycle
br_type  input  3  0 cond, 1 JAL, 2 JALR, 3 call, 4 return, 5-7 reserved
br_from  input  DATA_WIDTH  source PC
br_to  input  DATA_WIDTH  target PC
csr_req  input  2  bit1 access, bit0 write (write only when bit1=1)
csr_addr  input  ADDR_W  window address
csr_wdata  input  DATA_WIDTH  write data
csr_rdata  output  DATA_WIDTH  registered read data
csr_rvalid  output  1  read data valid (one-cycle pulse)
freeze_irq  output  1  level; high while frozen

Behaviour:
- Address map, addr[ADDR_W-1:ADDR_W-2]:
  - 00 from[i]
  - 01 to[i]
  - 10 info[i] = {type[2:0] in bits 2:0, valid in bit 3}
  - 11 control, indexed by low bits: 0 TOS, 1 CTRL, 2 COUNT; other indices read 0, writes ignored.
- CTRL bits:
  - [0] enable, reset 0
  - [1] freeze_en, reset 0
  - [2] frozen, reset 0; writable, write 0 clears
  - [15:8] type_mask, reset 8'hFF
  - other bits read 0.
- TOS is the next slot to write, width $clog2(LBR_SIZE), reset 0. COUNT is saturating at LBR_SIZE, reset 0. All entries reset to 0.
- record = br_valid & ~stall & enable & ~frozen & type_mask[br_type].
- On record:
  - entry[TOS] <= {br_from, br_to, type, valid=1}
  - TOS <= TOS+1, wrapping modulo LBR_SIZE
  - COUNT <= min(COUNT+1, LBR_SIZE).
- Freeze: if freeze_en and a record writes slot LBR_SIZE-1, frozen <= 1 on the same edge. Further records are suppressed until software clears frozen.
- freeze_irq = frozen, registered. Reset value 0.
- CSR write when csr_req=2'b11: updates the addressed register at the clock edge. Writing TOS uses the low bits of csr_wdata. Writing COUNT saturates the value at LBR_SIZE.
- Collision: a CSR write in the same cycle as a record has priority. The record is dropped entirely, with no entry, TOS or COUNT update and no freeze.
- CSR read when csr_req=2'b10: csr_rdata <= addressed value and csr_rvalid <= 1 at the next edge. Otherwise csr_rvalid <= 0 and csr_rdata holds its value.
- Read-before-write: a read in the same cycle as a record returns pre-record state.
- Reset: csr_rdata=0, csr_rvalid=0, freeze_irq=0. A reset asserted mid-operation clears all state immediately, independent of clock.
- stall does not block CSR access.

Decomposition:
- lbr_pkg holds:
  - branch type codes
  - region codes 00/01/10/11
  - control register indices
  - CTRL bit positions
  - reset value of type_mask.
- Sub-module lbr_entry_ram holds three arrays (from, to, info). Each array has one synchronous write port with async clear and one combinational read port. The write mux (record vs CSR) stays in the top level.

Test Plan (LBR_SIZE=4, DATA_WIDTH=64):
- Reset, then read CTRL -> csr_rdata=0x0000FF00 with csr_rvalid one cycle after the request; TOS=0, COUNT=0.
- enable=1; inject branch type 1, from 0x100, to 0x200 -> from[0]=0x100, to[0]=0x200, info[0]=0x9, TOS=1, COUNT=1. Same branch with stall=1 -> no change.
- type_mask=0xFD; inject JAL (type 1) then JALR (type 2) -> only JALR is recorded, in slot 1; TOS=2.
- freeze_en=1, start from TOS=0; inject 5 branches -> slots 0-3 written, frozen=1 and freeze_irq=1 after the 4th, 5th dropped, TOS=0, COUNT=4. Write CTRL with frozen=0 -> irq drops and recording resumes.
- freeze_en=0; inject 6 branches -> wraps to TOS=2, COUNT saturates at 4, slots 0-1 hold branches 5-6.
- CSR write of TOS=3 in the same cycle as a branch -> TOS=3, branch dropped, COUNT unchanged. Assert reset mid-sequence -> all entries, TOS, COUNT and freeze_irq are 0 without a clock edge.
